video_scanout: RTL and testbench

- Downstream consumer of the 256x16 video RAM. Generates 640x480@60 raster timing from the pixel clock and fetches 1bpp bitmap words from the RAM through its registered read port.
- Serialises each word into pixels, magnified by 2^SCALE_LOG2, inside a fixed window. Drives 12-bit RGB plus syncs to the video output.
- Bitmap size is 64x64 px: 256 words, 4 words per row.

---
 rtl/video_scanout.sv | 127 ++++++++++++
 tb/tb_video_scanout.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/video_scanout.sv
// 640x480 raster generator that scans a 64x64 1bpp bitmap out of a registered-read RAM,
// magnified by 2^SCALE_LOG2 inside a fixed window; counters -> outputs in two cycles.
module video_scanout #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int WIN_X      = 192,
  parameter int WIN_Y      = 112,
  parameter int SCALE_LOG2 = 2,
  parameter bit SYNC_POL   = 1'b0
) (
  input  logic        i_clk,
  input  logic        i_rst,
  output logic [7:0]  o_ram_addr,
  output logic        o_ram_rd,
  input  logic [15:0] i_ram_data,
  input  logic [11:0] i_fg,
  input  logic [11:0] i_bg,
  input  logic [11:0] i_border,
  output logic [11:0] o_rgb,
  output logic        o_hsync,
  output logic        o_vsync,
  output logic        o_de,
  output logic        o_frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int WIN_W   = 64 << SCALE_LOG2;

  // Counters are 10 bits; all timing and window bounds must stay below 1024.
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [9:0] WX0      = 10'(WIN_X);
  localparam logic [9:0] WX1      = 10'(WIN_X + WIN_W);
  localparam logic [9:0] WY0      = 10'(WIN_Y);
  localparam logic [9:0] WY1      = 10'(WIN_Y + WIN_W);

  logic [9:0] hc;
  logic [9:0] vc;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      hc <= '0;
      vc <= '0;
    end else if (hc == H_LAST) begin
      hc <= '0;
      vc <= (vc == V_LAST) ? '0 : vc + 10'd1;
    end else begin
      hc <= hc + 10'd1;
    end
  end

  logic       de0;
  logic       in_win0;
  logic       hs0;
  logic       vs0;
  logic       fs0;
  logic [5:0] px;
  logic [5:0] fb_row;

  always_comb begin
    de0     = (hc < H_ACT) && (vc < V_ACT);
    in_win0 = de0 && (hc >= WX0) && (hc < WX1) && (vc >= WY0) && (vc < WY1);
    px      = 6'((hc - WX0) >> SCALE_LOG2);
    fb_row  = 6'((vc - WY0) >> SCALE_LOG2);
    hs0     = (hc >= HS_START) && (hc < HS_END);
    vs0     = (vc >= VS_START) && (vc < VS_END);
    fs0     = (hc == 10'd0) && (vc == 10'd0);
  end

  // The RAM registers this address itself, so it is driven straight from the counters.
  assign o_ram_addr = in_win0 ? {fb_row, px[5:4]} : 8'h00;
  assign o_ram_rd   = in_win0;

  logic       win1;
  logic [3:0] bitsel1;
  logic       de1;
  logic       hs1;
  logic       vs1;
  logic       fs1;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      win1          <= 1'b0;
      bitsel1       <= 4'd0;
      de1           <= 1'b0;
      hs1           <= 1'b0;
      vs1           <= 1'b0;
      fs1           <= 1'b0;
      o_rgb         <= 12'h000;
      o_de          <= 1'b0;
      o_hsync       <= ~SYNC_POL;
      o_vsync       <= ~SYNC_POL;
      o_frame_start <= 1'b0;
    end else begin
      win1          <= in_win0;
      bitsel1       <= ~px[3:0];
      de1           <= de0;
      hs1           <= hs0;
      vs1           <= vs0;
      fs1           <= fs0;
      o_de          <= de1;
      o_hsync       <= hs1 ? SYNC_POL : ~SYNC_POL;
      o_vsync       <= vs1 ? SYNC_POL : ~SYNC_POL;
      o_frame_start <= fs1;
      if (!de1)
        o_rgb <= 12'h000;
      else if (!win1)
        o_rgb <= i_border;
      else
        o_rgb <= i_ram_data[bitsel1] ? i_fg : i_bg;
    end
  end

endmodule

// File: tb/tb_video_scanout.sv
// Bench for video_scanout: a reference raster model computed from pixel positions is compared
// against every output each cycle; vertical timing is shortened so whole frames stay short.
module tb_video_scanout;

  localparam int HA = 640, HF = 16, HS = 96, HB = 48, HT = HA + HF + HS + HB;
  localparam int VA = 48, VF = 2, VS = 2, VB = 3, VT = VA + VF + VS + VB;
  localparam int WX = 192, WY = 4, WW = 256;
  localparam int FRAME = HT * VT;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  ram_addr;
  logic        ram_rd;
  logic [15:0] ram_q;
  logic [11:0] fg, bg, border;
  logic [11:0] rgb;
  logic        hsync, vsync, de, fs;
  logic [15:0] mem [256];
  logic [23:0] obs;
  int          k;
  int          tests = 0;
  int          fails = 0;

  video_scanout #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .WIN_X(WX), .WIN_Y(WY), .SCALE_LOG2(2), .SYNC_POL(1'b0)
  ) dut (
    .i_clk(clk), .i_rst(rst), .o_ram_addr(ram_addr), .o_ram_rd(ram_rd),
    .i_ram_data(ram_q), .i_fg(fg), .i_bg(bg), .i_border(border),
    .o_rgb(rgb), .o_hsync(hsync), .o_vsync(vsync), .o_de(de), .o_frame_start(fs)
  );

  always #5 clk = ~clk;

  always @(posedge clk) ram_q <= mem[ram_addr];

  // k = clock edges since reset release, i.e. the raster position the counters hold.
  always @(posedge clk or posedge rst)
    if (rst) k <= 0;
    else     k <= k + 1;

  assign obs = {rgb, hsync, vsync, de, fs, ram_addr, ram_rd};

  function automatic logic in_window(input int x, input int y);
    return (x >= WX) && (x < WX + WW) && (y >= WY) && (y < WY + WW) && (x < HA) && (y < VA);
  endfunction

  function automatic logic [11:0] pix(input int x, input int y);
    logic [15:0] w;
    int bi;
    w  = mem[8'(((y - WY) / 4) * 4 + (x - WX) / 64)];
    bi = 15 - ((x - WX) / 4) % 16;
    return w[4'(bi)] ? fg : bg;
  endfunction

  function automatic logic [23:0] m_out(input int kk);
    int p, x, y, cx, cy;
    logic [11:0] c;
    logic [7:0]  a;
    logic r, h, v, d, f;
    cx = kk % HT;
    cy = (kk / HT) % VT;
    r  = in_window(cx, cy);
    a  = r ? 8'(((cy - WY) / 4) * 4 + (cx - WX) / 64) : 8'h00;
    p  = kk - 2;
    if (p < 0) begin
      c = 12'h000; h = 1'b1; v = 1'b1; d = 1'b0; f = 1'b0;
    end else begin
      x = p % HT;
      y = (p / HT) % VT;
      d = (x < HA) && (y < VA);
      h = !((x >= HA + HF) && (x < HA + HF + HS));
      v = !((y >= VA + VF) && (y < VA + VF + VS));
      f = (x == 0) && (y == 0);
      c = !d ? 12'h000 : (in_window(x, y) ? pix(x, y) : border);
    end
    return {c, h, v, d, f, a, r};
  endfunction

  task automatic do_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic pick_colours;
    fg     = 12'h800 | 12'($urandom_range(0, 2047));
    bg     = fg ^ 12'h00F;
    border = 12'h0A0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    pick_colours();
    repeat (3) @(negedge clk);
    tests++; if (rgb !== 12'h000) begin fails++; $display("FAIL reset_rgb: got %h want 000", rgb); end
    tests++; if (hsync !== 1'b1) begin fails++; $display("FAIL reset_hsync: got %b want 1", hsync); end
    tests++; if (vsync !== 1'b1) begin fails++; $display("FAIL reset_vsync: got %b want 1", vsync); end
    tests++; if (de !== 1'b0) begin fails++; $display("FAIL reset_de: got %b want 0", de); end
    tests++; if (fs !== 1'b0) begin fails++; $display("FAIL reset_fs: got %b want 0", fs); end
    tests++; if (ram_addr !== 8'h00) begin fails++; $display("FAIL reset_addr: got %h want 00", ram_addr); end
    tests++; if (ram_rd !== 1'b0) begin fails++; $display("FAIL reset_rd: got %b want 0", ram_rd); end
  endtask

  task automatic test_frame;
    int bad = 0, bad_k = 0, falls = 0, last_fall = -1, per_bad = 0, len_bad = 0;
    int vs_low = 0, vfalls = 0, vfall_bad = 0, de_cnt = 0, fs_cnt = 0, fs_bad = 0;
    int k_addr, k_last;
    logic [23:0] bad_obs = '0, bad_exp = '0;
    logic hs_prev = 1'b1, vs_prev = 1'b1;
    logic [15:0] w10 = 16'h002A;
    for (int a = 0; a < 256; a++) mem[a] = 16'(a);
    pick_colours();
    k_addr = (WY + 40) * HT + WX + 148;
    k_last = (VA - 1) * HT + HA - 1 + 2;
    do_reset();
    for (int i = 0; i < FRAME + 3; i++) begin
      if (obs !== m_out(k)) begin
        if (bad == 0) begin bad_k = k; bad_obs = obs; bad_exp = m_out(k); end
        bad++;
      end
      if (hs_prev && !hsync) begin
        falls++;
        if (last_fall >= 0 && k - last_fall != HT) per_bad++;
        last_fall = k;
      end
      if (!hs_prev && hsync && last_fall >= 0 && k - last_fall != HS) len_bad++;
      if (vs_prev && !vsync) begin
        vfalls++;
        if ((k - 2) % HT != 0) vfall_bad++;
      end
      if (k < FRAME + 2) begin
        if (!vsync) vs_low++;
        if (de) de_cnt++;
      end
      if (fs) begin
        fs_cnt++;
        if (k != 2 && k != FRAME + 2) fs_bad++;
      end
      if (k == 2) begin
        tests++; if (rgb !== 12'h0A0) begin fails++; $display("FAIL border_first: got %h want 0a0", rgb); end
      end
      if (k == k_last) begin
        tests++; if (rgb !== 12'h0A0) begin fails++; $display("FAIL border_last: got %h want 0a0", rgb); end
      end
      if (k == k_addr) begin
        tests++;
        if (ram_addr !== 8'h2A || ram_rd !== 1'b1) begin
          fails++; $display("FAIL addr_row10: got %h/%b want 2a/1", ram_addr, ram_rd);
        end
      end
      if (k == k_addr + 2) begin
        tests++;
        if (rgb !== (w10[10] ? fg : bg)) begin
          fails++; $display("FAIL pixel_bit10: got %h want %h", rgb, w10[10] ? fg : bg);
        end
      end
      hs_prev = hsync;
      vs_prev = vsync;
      @(negedge clk);
    end
    tests++;
    if (bad != 0) begin
      fails++; $display("FAIL frame_model: %0d cycles differ, first k=%0d got %h want %h", bad, bad_k, bad_obs, bad_exp);
    end
    tests++; if (falls != VT) begin fails++; $display("FAIL hsync_count: got %0d want %0d", falls, VT); end
    tests++; if (per_bad != 0) begin fails++; $display("FAIL hsync_period: %0d periods not %0d", per_bad, HT); end
    tests++; if (len_bad != 0) begin fails++; $display("FAIL hsync_width: %0d pulses not %0d", len_bad, HS); end
    tests++; if (vs_low != VS * HT) begin fails++; $display("FAIL vsync_width: got %0d want %0d", vs_low, VS * HT); end
    tests++;
    if (vfalls != 1 || vfall_bad != 0) begin
      fails++; $display("FAIL vsync_edge: got %0d falls, %0d misaligned want 1, 0", vfalls, vfall_bad);
    end
    tests++; if (de_cnt != HA * VA) begin fails++; $display("FAIL de_count: got %0d want %0d", de_cnt, HA * VA); end
    tests++;
    if (fs_cnt != 2 || fs_bad != 0) begin
      fails++; $display("FAIL frame_start: got %0d pulses, %0d misplaced want 2, 0", fs_cnt, fs_bad);
    end
  endtask

  task automatic test_latency;
    int bad = 0, bad_k = 0, lat_bad = 0, lat_n = 0, p, x, y;
    logic [23:0] bad_obs = '0, bad_exp = '0;
    logic [11:0] want;
    for (int a = 0; a < 256; a++) mem[a] = 16'h0000;
    mem[0] = 16'h8000;
    fg = 12'hF00;
    bg = 12'h00F;
    border = {4'h0, 8'($urandom_range(16, 255))};
    do_reset();
    for (int i = 0; i < (WY + 5) * HT; i++) begin
      if (obs !== m_out(k)) begin
        if (bad == 0) begin bad_k = k; bad_obs = obs; bad_exp = m_out(k); end
        bad++;
      end
      if (k == WY * HT + WX) begin
        tests++;
        if (ram_addr !== 8'h00 || ram_rd !== 1'b1) begin
          fails++; $display("FAIL addr_origin: got %h/%b want 00/1", ram_addr, ram_rd);
        end
      end
      p = k - 2;
      x = p % HT;
      y = p / HT;
      if (p >= 0 && y >= WY && y <= WY + 3 && x >= WX && x <= WX + 4) begin
        want = (x < WX + 4) ? 12'hF00 : 12'h00F;
        lat_n++;
        if (rgb !== want) lat_bad++;
      end
      if (p >= 0 && y == WY + 4 && x == WX) begin
        tests++; if (rgb !== 12'h00F) begin fails++; $display("FAIL row1_start: got %h want 00f", rgb); end
      end
      @(negedge clk);
    end
    tests++;
    if (bad != 0) begin
      fails++; $display("FAIL latency_model: %0d cycles differ, first k=%0d got %h want %h", bad, bad_k, bad_obs, bad_exp);
    end
    tests++;
    if (lat_bad != 0 || lat_n != 20) begin
      fails++; $display("FAIL latency_block: %0d of %0d pixels wrong (want 0 of 20)", lat_bad, lat_n);
    end
  endtask

  task automatic test_mid_reset;
    int bad = 0, bad_k = 0, fs_first = -1, hs_first = -1;
    logic [23:0] bad_obs = '0, bad_exp = '0;
    logic [23:0] rst_vec = {12'h000, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0};
    for (int a = 0; a < 256; a++) mem[a] = 16'($urandom);
    pick_colours();
    do_reset();
    for (int i = 0; i < 10 * HT + 417; i++) @(negedge clk);
    tests++; if (ram_rd !== 1'b1) begin fails++; $display("FAIL premid_rd: got %b want 1", ram_rd); end
    #2 rst = 1'b1;
    #1;
    tests++; if (obs !== rst_vec) begin fails++; $display("FAIL async_reset: got %h want %h", obs, rst_vec); end
    repeat (2) @(negedge clk);
    tests++; if (obs !== rst_vec) begin fails++; $display("FAIL held_reset: got %h want %h", obs, rst_vec); end
    rst = 1'b0;
    for (int i = 0; i < 1700; i++) begin
      if (obs !== m_out(k)) begin
        if (bad == 0) begin bad_k = k; bad_obs = obs; bad_exp = m_out(k); end
        bad++;
      end
      if (fs && fs_first < 0) fs_first = k;
      if (!hsync && hs_first < 0) hs_first = k;
      @(negedge clk);
    end
    tests++;
    if (bad != 0) begin
      fails++; $display("FAIL restart_model: %0d cycles differ, first k=%0d got %h want %h", bad, bad_k, bad_obs, bad_exp);
    end
    tests++; if (fs_first != 2) begin fails++; $display("FAIL restart_fs: got cycle %0d want 2", fs_first); end
    tests++;
    if (hs_first != HA + HF + 2) begin
      fails++; $display("FAIL restart_hsync: got cycle %0d want %0d", hs_first, HA + HF + 2);
    end
  endtask

  task automatic test_right_edge;
    int bad = 0, bad_k = 0, edge_bad = 0, p, x, y;
    logic [23:0] bad_obs = '0, bad_exp = '0;
    for (int a = 0; a < 256; a++) mem[a] = 16'h0000;
    mem[3] = 16'h0001;
    pick_colours();
    do_reset();
    for (int i = 0; i < (WY + 2) * HT; i++) begin
      if (obs !== m_out(k)) begin
        if (bad == 0) begin bad_k = k; bad_obs = obs; bad_exp = m_out(k); end
        bad++;
      end
      p = k - 2;
      x = p % HT;
      y = p / HT;
      if (p >= 0 && y == WY) begin
        if (x == WX + 251 && rgb !== bg) edge_bad++;
        if (x >= WX + 252 && x <= WX + 255 && rgb !== fg) edge_bad++;
        if (x == WX + 256) begin
          tests++; if (rgb !== border) begin fails++; $display("FAIL edge_border: got %h want %h", rgb, border); end
        end
      end
      @(negedge clk);
    end
    tests++;
    if (bad != 0) begin
      fails++; $display("FAIL edge_model: %0d cycles differ, first k=%0d got %h want %h", bad, bad_k, bad_obs, bad_exp);
    end
    tests++; if (edge_bad != 0) begin fails++; $display("FAIL edge_pixels: %0d wrong, want 0", edge_bad); end
  endtask

  initial begin
    for (int a = 0; a < 256; a++) mem[a] = 16'h0000;
    test_reset();
    test_frame();
    test_latency();
    test_mid_reset();
    test_right_edge();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
